// File: rtl/cpu_timing_if.sv
// Bundle of CPU timing signals shared between the timing generator and its consumers.
// The master side is the generator; the slave side is the CPU/bus logic that supplies contend.
interface cpu_timing_if;
    logic       contend;
    logic       ne;
    logic       pe;
    logic       irq;
    logic [7:0] hc;
    logic [8:0] vc;
    logic       frame;

    modport master (
        input  contend,
        output ne, pe, irq, hc, vc, frame
    );

    modport slave (
        output contend,
        input  ne, pe, irq, hc, vc, frame
    );
endinterface

// File: rtl/cpu_timing.sv
// CPU clock-enable and raster timing generator: 8 system clocks per T-state, with
// memory-contention stalls of whole T-states, a frame-start /INT pulse and a frame strobe.
module cpu_timing #(
    parameter int LINE_T  = 224,
    parameter int LINES   = 312,
    parameter int INT_LEN = 32
) (
    input  logic         clock,
    input  logic         reset,
    cpu_timing_if.master bus
);
    localparam logic [7:0] LP_HC_LAST = 8'(LINE_T - 1);
    localparam logic [8:0] LP_VC_LAST = 9'(LINES - 1);
    localparam logic [7:0] LP_INT_LEN = 8'(INT_LEN);

    logic [2:0] r_phase;
    logic [7:0] r_hc;
    logic [8:0] r_vc;
    logic       r_stall;
    logic       r_ne;
    logic       r_pe;
    logic       r_irq;
    logic       r_frame;

    logic [7:0] w_hcNext;
    logic [8:0] w_vcNext;
    logic       w_window;

    always_comb begin
        w_hcNext = r_hc + 8'd1;
        w_vcNext = r_vc;
        if (r_hc == LP_HC_LAST) begin
            w_hcNext = 8'd0;
            w_vcNext = (r_vc == LP_VC_LAST) ? 9'd0 : r_vc + 9'd1;
        end
    end

    // Window is judged on the T-state that is about to start, not the one ending.
    assign w_window = (w_vcNext >= 9'd64) && (w_vcNext <= 9'd255) &&
                      !w_hcNext[7] && (w_hcNext[2:0] <= 3'd5);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase <= 3'd0;
            r_hc    <= 8'd0;
            r_vc    <= 9'd0;
            r_stall <= 1'b0;
            r_ne    <= 1'b0;
            r_pe    <= 1'b0;
            r_irq   <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_phase <= r_phase + 3'd1;
            r_ne    <= (r_phase == 3'd3) && !r_stall;
            r_pe    <= (r_phase == 3'd7) && !r_stall;
            r_irq   <= !((r_vc == 9'd0) && (r_hc < LP_INT_LEN));
            r_frame <= (r_phase == 3'd0) && (r_hc == 8'd0) && (r_vc == 9'd0);
            if (r_phase == 3'd7) begin
                r_hc    <= w_hcNext;
                r_vc    <= w_vcNext;
                r_stall <= bus.contend && w_window;
            end
        end
    end

    assign bus.ne    = r_ne;
    assign bus.pe    = r_pe;
    assign bus.irq   = r_irq;
    assign bus.hc    = r_hc;
    assign bus.vc    = r_vc;
    assign bus.frame = r_frame;
endmodule

// File: doc/cpu_timing.md
CPU_TIMING -- requirements
Module: cpu_timing

Interface
REQ-001 The block SHALL have parameter LINE_T, default 224, giving T-states per scanline.
REQ-002 The block SHALL have parameter LINES, default 312, giving scanlines per frame.
REQ-003 The block SHALL have parameter INT_LEN, default 32, giving the /INT low width in T-states.
REQ-004 Port clock  input  1  system clock, 8 clocks per CPU T-state; the block has one clock.
REQ-005 Port reset  input  1  reset, synchronous and active-high.
REQ-006 Port contend  input  1  high when the CPU's current cycle addresses contended memory or I/O.
REQ-007 Port ne  output  1  CPU falling-edge clock enable, one-clock pulse.
REQ-008 Port pe  output  1  CPU rising-edge clock enable, one-clock pulse.
REQ-009 Port irq  output  1  active-low maskable interrupt request, routed to the CPU INT input.
REQ-010 Port hc  output  8  horizontal T-state counter, range 0..LINE_T-1.
REQ-011 Port vc  output  9  scanline counter, range 0..LINES-1.
REQ-012 Port frame  output  1  one-clock pulse on the first clock of each frame (hc=0, vc=0, phase=0).

Function
REQ-013 The block SHALL hold a 3-bit phase counter that increments every clock and wraps from 7 to 0.
REQ-014 The block SHALL increment hc on each clock with phase=7; at hc=LINE_T-1 it SHALL wrap hc to 0 and increment vc.
REQ-015 The block SHALL wrap vc from LINES-1 to 0 on the same clock that hc wraps.
REQ-016 The block SHALL register a stall flag on each clock with phase=7, set to contend AND window, where window is evaluated on the post-edge hc/vc values.
REQ-017 The window SHALL be true when vc is in 64..255, hc is in 0..127, and hc[2:0] is in 0..5; it SHALL be false otherwise, including hc[2:0] in 6..7.
REQ-018 Both ne and pe SHALL be registered, and SHALL be asserted for one clock when phase=3 (ne) or phase=7 (pe), provided stall=0.
REQ-019 While stall=1, both ne and pe SHALL be suppressed for that entire T-state, while the phase counter, hc and vc keep advancing.
REQ-020 Consecutive contended T-states SHALL be stalled back-to-back; the stall flag SHALL be re-evaluated every T-state, with no hysteresis.
REQ-021 irq SHALL be registered, and SHALL be low exactly while vc=0 and hc<INT_LEN; otherwise it SHALL be high.
REQ-022 irq SHALL be independent of contend and of stall.
REQ-023 frame SHALL be registered, and SHALL be high for one clock per frame.
REQ-024 Changes on contend in the middle of a T-state (phase≠7) SHALL have no effect until the next phase=7 sample.

Reset
REQ-025 While reset=1, the block SHALL set phase=0, hc=0, vc=0, stall=0, ne=0, pe=0, irq=1 and frame=0.
REQ-026 Reset SHALL have priority over all counting and contention logic.
REQ-027 When asserted mid-frame or mid-T-state, reset SHALL abandon the current T-state.
REQ-028 After reset deasserts, counting SHALL restart from phase=0, hc=0, vc=0.
REQ-029 On the first clock after reset deasserts, irq SHALL go low and frame SHALL pulse.

Verification
REQ-030 Reset test: hold reset for 5 clocks, then release -> during reset ne=pe=0, irq=1, hc=vc=0; on the first clock after release irq=0 and frame=1; the first ne comes 4 clocks after release and the first pe 8 clocks after release.
REQ-031 Free-run with contend=0 -> pe period is exactly 8 clocks and ne trails pe by 4 clocks; hc goes 223→0 with vc+1; vc goes 311→0; frame period is 559104 clocks.
REQ-032 IRQ width -> irq is low for exactly 256 clocks (hc 0..31, vc=0) per frame and is never low at vc≠0.
REQ-033 Contention with contend=1 held at vc=100, hc 0..15 -> ne/pe are suppressed for hc 0..5 and 8..13, and present for hc 6, 7, 14, 15; hc/vc advance unchanged.
REQ-034 Out-of-window contention with contend=1 at vc=10 or at vc=100, hc=150 -> no ne/pe suppression.
REQ-035 Mid-frame reset: assert reset at vc=200, hc=57, phase=5 for 1 clock -> the counters restart from 0, with no stray ne/pe pulse during or on the clock after reset.
